fv_ccp_double_rd_port_queue: RTL and testbench

FV_CCP_DOUBLE_RD_PORT_QUEUE -- requirements
Module: fv_ccp_double_rd_port_queue

---
 rtl/fv_ccp_queue_pkg.sv | 7 +
 rtl/fv_ccp_ptr_wrap_inc.sv | 13 +
 rtl/fv_ccp_double_rd_port_queue.sv | 79 +++++++
 tb/tb_fv_ccp_double_rd_port_queue.sv | 109 ++++++++++
 4 files changed

// File: rtl/fv_ccp_queue_pkg.sv
// fv_ccp_queue_pkg: pointer wrap helper and protocol error causes shared by the ccp queues
package fv_ccp_queue_pkg;
  typedef enum logic [1:0] {ERR_OVF, ERR_UNF_1, ERR_UNF_2, ERR_ORDER} err_cause_e;
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned inc, input int unsigned depth);
    return (ptr + inc >= depth) ? ptr + inc - depth : ptr + inc;
  endfunction
endpackage

// File: rtl/fv_ccp_ptr_wrap_inc.sv
// fv_ccp_ptr_wrap_inc: advances a queue pointer by 0..2 modulo DEPTH
module fv_ccp_ptr_wrap_inc
  import fv_ccp_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PNT_W = $clog2(DEPTH)
) (
  input  logic [PNT_W-1:0] ptr,
  input  logic [1:0]       inc,
  output logic [PNT_W-1:0] nxt
);
  assign nxt = PNT_W'(ptr_wrap(32'(ptr), 32'(inc), DEPTH));
endmodule

// File: rtl/fv_ccp_double_rd_port_queue.sv
// fv_ccp_double_rd_port_queue: single-push queue exposing head and head+1 with same-cycle bypass
module fv_ccp_double_rd_port_queue
  import fv_ccp_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int PNT_W        = $clog2(QUEUE_DEPTH),
  parameter int MEM_W        = 4,
  parameter int CNT_W        = $clog2(QUEUE_DEPTH + 1),
  parameter bit PROTO_ASSERT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [MEM_W-1:0] data_in,
  input  logic             pop_1,
  input  logic             pop_2,
  output logic [MEM_W-1:0] data_out_1,
  output logic [MEM_W-1:0] data_out_2,
  output logic             valid_1,
  output logic             valid_2,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             proto_err
);
  logic [MEM_W-1:0] mem [0:QUEUE_DEPTH-1];
  logic [PNT_W-1:0] wr_pnt, rd_pnt, wr_nxt, rd_nxt, rd_p1;
  logic [3:0]       err_v;
  logic [1:0]       npop, rd_inc;
  logic             cnt_ge1, cnt_ge2, cnt_eq1, bypass, err, we;
  assign cnt_ge1 = count != '0;
  assign cnt_ge2 = count >= CNT_W'(2);
  assign cnt_eq1 = count == CNT_W'(1);
  assign empty   = !cnt_ge1;
  assign full    = count == CNT_W'(QUEUE_DEPTH);
  assign valid_1 = cnt_ge1 | push;
  assign valid_2 = cnt_ge2 | (cnt_eq1 & push);
  assign rd_p1   = PNT_W'(ptr_wrap(32'(rd_pnt), 1, QUEUE_DEPTH));
  assign data_out_1 = cnt_ge1 ? mem[rd_pnt] : push ? data_in : '0;
  assign data_out_2 = cnt_ge2 ? mem[rd_p1] : (cnt_eq1 & push) ? data_in : '0;
  assign err_v[ERR_OVF]   = push & full & !pop_1;
  assign err_v[ERR_UNF_1] = pop_1 & !valid_1;
  assign err_v[ERR_UNF_2] = pop_2 & !valid_2;
  assign err_v[ERR_ORDER] = pop_2 & !pop_1;
  assign err    = |err_v;
  // a bypassed push consumes exactly one of the pops without touching storage
  assign bypass = push & pop_1 & (empty | (cnt_eq1 & pop_2));
  assign npop   = {1'b0, pop_1} + {1'b0, pop_2};
  assign rd_inc = npop - {1'b0, bypass};
  assign we     = push & !bypass & !err;
  fv_ccp_ptr_wrap_inc #(.DEPTH(QUEUE_DEPTH), .PNT_W(PNT_W)) u_wr_inc (
    .ptr(wr_pnt), .inc({1'b0, we}), .nxt(wr_nxt)
  );
  fv_ccp_ptr_wrap_inc #(.DEPTH(QUEUE_DEPTH), .PNT_W(PNT_W)) u_rd_inc (
    .ptr(rd_pnt), .inc(rd_inc), .nxt(rd_nxt)
  );
  always_ff @(posedge clk)
    if (we) mem[wr_pnt] <= data_in;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_pnt    <= '0;
      rd_pnt    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | err;
      if (!err) begin
        wr_pnt <= wr_nxt;
        rd_pnt <= rd_nxt;
        count  <= count + CNT_W'(push) - CNT_W'(npop);
      end
    end
  if (PROTO_ASSERT) begin : g_proto
    a_ovf:   assert property (@(posedge clk) disable iff (!reset_n) !err_v[ERR_OVF]);
    a_unf_1: assert property (@(posedge clk) disable iff (!reset_n) !err_v[ERR_UNF_1]);
    a_unf_2: assert property (@(posedge clk) disable iff (!reset_n) !err_v[ERR_UNF_2]);
    a_order: assert property (@(posedge clk) disable iff (!reset_n) !err_v[ERR_ORDER]);
  end
endmodule

// File: tb/tb_fv_ccp_double_rd_port_queue.sv
// tb_fv_ccp_double_rd_port_queue: scoreboard bench with directed vectors for the double-read queue
module tb_fv_ccp_double_rd_port_queue;
  localparam int S_D1 = 0, S_D2 = 1, S_V1 = 2, S_V2 = 3, S_CNT = 4, S_EMP = 5, S_FULL = 6, S_ERR = 7, S_WR = 8;
  typedef struct {int cyc; int sig; logic [7:0] v;} exp_t;
  logic       clk = 0, reset_n = 0, push = 0, pop_1 = 0, pop_2 = 0;
  logic [3:0] data_in = 0, data_out_1, data_out_2;
  logic       valid_1, valid_2, empty, full, proto_err;
  logic [2:0] count;
  int         cyc = 0, errors = 0, checks = 0;
  exp_t       q[$];
  fv_ccp_double_rd_port_queue #(.QUEUE_DEPTH(4), .MEM_W(4), .PROTO_ASSERT(0)) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .data_in(data_in), .pop_1(pop_1), .pop_2(pop_2),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .valid_1(valid_1), .valid_2(valid_2),
    .count(count), .empty(empty), .full(full), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic string sname(input int s);
    string n[9] = '{"data_out_1", "data_out_2", "valid_1", "valid_2", "count", "empty", "full", "proto_err", "wr_pnt"};
    return n[s];
  endfunction
  function automatic logic [7:0] actual(input int s);
    case (s)
      S_D1:    return 8'(data_out_1);
      S_D2:    return 8'(data_out_2);
      S_V1:    return 8'(valid_1);
      S_V2:    return 8'(valid_2);
      S_CNT:   return 8'(count);
      S_EMP:   return 8'(empty);
      S_FULL:  return 8'(full);
      S_ERR:   return 8'(proto_err);
      default: return 8'(dut.wr_pnt);
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [7:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %0h expected %0h", sname(e.sig), e.cyc, a, e.v);
      end
    end
  task automatic step(input logic p, input logic [3:0] d, input logic a, input logic b);
    @(posedge clk);
    #1;
    push = p; data_in = d; pop_1 = a; pop_2 = b;
  endtask
  task automatic ex(input int s, input int v);
    q.push_back('{cyc, s, 8'(v)});
  endtask
  task automatic fill4();
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0);
  endtask
  initial begin
    step(0, 0, 0, 0); ex(S_CNT, 0); ex(S_EMP, 1); ex(S_FULL, 0); ex(S_V1, 0); ex(S_ERR, 0);
    step(1, 3, 0, 0); ex(S_V1, 1); ex(S_D1, 3); ex(S_V2, 0); ex(S_CNT, 0);
    step(0, 0, 0, 0); reset_n = 1; ex(S_CNT, 0);
    step(1, 1, 0, 0); ex(S_D1, 1); ex(S_V1, 1); ex(S_CNT, 0);
    step(1, 2, 0, 0); ex(S_D1, 1); ex(S_D2, 2); ex(S_V2, 1); ex(S_CNT, 1);
    step(1, 3, 0, 0); ex(S_CNT, 2);
    step(1, 4, 0, 0); ex(S_CNT, 3);
    step(0, 0, 1, 1); ex(S_CNT, 4); ex(S_FULL, 1); ex(S_D1, 1); ex(S_D2, 2);
    step(0, 0, 1, 1); ex(S_CNT, 2); ex(S_FULL, 0); ex(S_D1, 3); ex(S_D2, 4);
    step(0, 0, 0, 0); ex(S_CNT, 0); ex(S_EMP, 1); ex(S_V1, 0); ex(S_V2, 0); ex(S_D1, 0); ex(S_WR, 0);
    step(1, 7, 1, 0); ex(S_D1, 7); ex(S_V1, 1); ex(S_CNT, 0);
    step(0, 0, 0, 0); ex(S_CNT, 0); ex(S_EMP, 1); ex(S_WR, 0);
    step(1, 5, 0, 0); ex(S_D1, 5); ex(S_CNT, 0);
    step(1, 9, 1, 1); ex(S_D1, 5); ex(S_D2, 9); ex(S_V2, 1); ex(S_CNT, 1);
    step(0, 0, 0, 0); ex(S_CNT, 0); ex(S_EMP, 1); ex(S_WR, 1);
    fill4();
    step(1, 10, 1, 0); ex(S_CNT, 4); ex(S_FULL, 1); ex(S_D1, 1);
    step(0, 0, 0, 0); ex(S_CNT, 4); ex(S_FULL, 1); ex(S_D1, 2); ex(S_D2, 3);
    step(0, 0, 1, 0); ex(S_D1, 2);
    step(0, 0, 1, 0); ex(S_D1, 3);
    step(0, 0, 1, 0); ex(S_D1, 4);
    step(0, 0, 1, 0); ex(S_D1, 10); ex(S_CNT, 1);
    step(0, 0, 0, 0); ex(S_CNT, 0); ex(S_EMP, 1);
    step(1, 11, 0, 0);
    step(1, 12, 0, 0);
    step(1, 13, 0, 0);
    step(0, 0, 0, 0); ex(S_CNT, 3); ex(S_D1, 11); ex(S_D2, 12);
    step(0, 0, 0, 0); reset_n = 0; ex(S_CNT, 0); ex(S_EMP, 1); ex(S_V1, 0);
    step(0, 0, 0, 0); reset_n = 1; ex(S_CNT, 0);
    step(1, 6, 0, 0); ex(S_D1, 6); ex(S_CNT, 0);
    step(0, 0, 1, 0); ex(S_D1, 6); ex(S_CNT, 1); ex(S_WR, 1);
    step(0, 0, 0, 0); ex(S_CNT, 0); ex(S_ERR, 0);
    step(0, 0, 0, 1); ex(S_ERR, 0); ex(S_CNT, 0);
    step(0, 0, 0, 0); ex(S_ERR, 1); ex(S_CNT, 0); ex(S_EMP, 1);
    step(0, 0, 0, 0); ex(S_ERR, 1);
    step(0, 0, 0, 0); reset_n = 0; ex(S_ERR, 0);
    step(0, 0, 0, 0); reset_n = 1;
    fill4();
    step(1, 15, 0, 0); ex(S_CNT, 4); ex(S_FULL, 1); ex(S_ERR, 0);
    step(0, 0, 0, 0); ex(S_CNT, 4); ex(S_ERR, 1); ex(S_D1, 1); ex(S_WR, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
